// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment pattern constants and BCD to 7-segment decode for the scan driver
package seg7_pkg;

    // Patterns are {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7C;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h67;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_ALL   = 7'h7F;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bcd7_decode.sv
// rtl/bcd7_decode.sv - combinational BCD to 7-segment decode with lamp test over blank over decode
module bcd7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       lt_n,
    input  logic       bl_n,
    output logic [6:0] seg
);

    always_comb begin
        seg = bcd_to_seg(bcd);
        if (!bl_n) begin
            seg = SEG_BLANK;
        end
        if (!lt_n) begin
            seg = SEG_ALL;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit 7-segment scan driver; LEADING_ZERO_BLANK_EN adds leading-zero suppression
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   bcd_in,
    input  logic                    le,
    input  logic                    lt_n,
    input  logic                    bl_n,
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     dig
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
    localparam logic [N_DIGITS-1:0] DIG_OFF = {N_DIGITS{DIG_ACTIVE_LOW != 0}};

    logic [N_DIGITS-1:0][3:0] latch_q, latch_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [6:0]               seg_q, seg_d;
    logic [N_DIGITS-1:0]      dig_q, dig_d;

    logic [3:0]               cur_bcd;
    logic [N_DIGITS-1:0]      onehot;
    logic                     dec_bl_n;
    logic [6:0]               dec_seg;

`ifdef LEADING_ZERO_BLANK_EN
    logic [N_DIGITS-1:0] lz_mask;
    logic                lz_run;

    // Walk down from the top digit; suppression holds only while every higher code is zero
    always_comb begin
        lz_mask = '0;
        lz_run  = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            lz_run     = lz_run && (latch_q[i] == 4'd0);
            lz_mask[i] = lz_run;
        end
    end

    assign dec_bl_n = bl_n & ~lz_mask[idx_q];
`else
    assign dec_bl_n = bl_n;
`endif

    assign cur_bcd = latch_q[idx_q];

    bcd7_decode u_decode (
        .bcd  (cur_bcd),
        .lt_n (lt_n),
        .bl_n (dec_bl_n),
        .seg  (dec_seg)
    );

    always_comb begin
        latch_d = le ? bcd_in : latch_q;

        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        onehot        = '0;
        onehot[idx_q] = 1'b1;
        dig_d = (DIG_ACTIVE_LOW != 0) ? ~onehot : onehot;
        seg_d = (SEG_ACTIVE_LOW != 0) ? ~dec_seg : dec_seg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_OFF;
            dig_q   <= DIG_OFF;
        end else begin
            latch_q <= latch_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
        end
    end

    assign seg = seg_q;
    assign dig = dig_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Multiplexed N-digit 7-segment display driver, successor to the single-digit BCD-to-7-segment decoder. Latches N BCD digits on a load strobe and time-multiplexes them onto one shared segment bus with a one-hot digit-enable bus. Provides CD4511-style lamp test and blanking, and blanks invalid codes. Sits between the counter/datapath logic and the board's common-anode/common-cathode display pins.

Parameters:
N_DIGITS, 4, number of digits scanned (>=1)
SCAN_DIV, 1000, clk cycles each digit is held active (>=1)
SEG_ACTIVE_LOW, 0, 1 = invert seg outputs (common-anode)
DIG_ACTIVE_LOW, 0, 1 = invert dig outputs

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
bcd_in  input  4*N_DIGITS  packed BCD; digit i = bcd_in[4i+3:4i]; digit 0 = least significant
le  input  1  load strobe; active high; sampled on the rising edge
lt_n  input  1  lamp test, active low
bl_n  input  1  blank, active low
seg  output  7  segments {g,f,e,d,c,b,a}, registered
dig  output  N_DIGITS  one-hot digit enable, registered

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous active-low (rst_n).
- Reset state:
  - latch = 0 for all digits
  - scan counter = 0
  - digit index idx = 0
  - seg = all off
  - dig = all inactive
  - Inactive/off levels respect the polarity parameters.
- Load:
  - le=1 at edge k: latch <= bcd_in at edge k.
  - The displayed value reflects the new data at edge k+1.
  - le=1 on consecutive cycles reloads every cycle.
- Scan counter:
  - Counts 0..SCAN_DIV-1.
  - On terminal count it returns to 0 and idx advances.
  - idx wraps from N_DIGITS-1 to 0.
  - SCAN_DIV=1: idx advances every cycle.
- Output registers, updated every edge:
  - dig <= onehot(idx)
  - seg <= decode(latch[idx])
  - Latency: one cycle from any change of idx, latch, lt_n or bl_n to the outputs.
- Decode (active-high before inversion):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7C, 7=07, 8=7F, 9=67
  - Codes 10-15 = 00 (blank).
- Priority:
  - lt_n=0 → seg=7F.
  - Otherwise bl_n=0 → seg=00.
  - Otherwise decode.
  - dig keeps scanning in every case.
- Simultaneous events: le together with a scan advance at the same edge: the newly indexed digit shows the new latch data one edge later; no glitch to stale data beyond that one cycle.
- Reset mid-scan: immediate return to the reset state; the scan restarts at digit 0 with a full SCAN_DIV period.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined:
  - Starting from digit N_DIGITS-1 downward, digits whose latched code is 0 are blanked (seg=00) until the first nonzero code is reached.
  - Digit 0 is never blanked.
  - A code of 10-15 ends suppression.
  - lt_n overrides.
  - The suppression mask is computed from the latch contents.
- Undefined: zeros display normally; no extra logic.

Decomposition:
- Package seg7_pkg:
  - segment pattern constants SEG_0..SEG_9, SEG_BLANK, SEG_ALL
  - the BCD→segment decode function
- Natural sub-module: bcd7_decode (combinational 4-bit → 7-segment, with lt_n/bl_n priority), instantiated once on the muxed digit.

Test Plan:
- Reset: rst_n=0 with N_DIGITS=4, SCAN_DIV=4 → seg=00, dig=0000; after release, dig=0001 at first edge, 0010 after 4 more cycles, wraps to 0001 after 16.
- Load and decode: bcd_in=16'h9876 with le pulse → over one scan frame, seg=7C with dig=0001, 07 with 0010, 7F with 0100, 67 with 1000.
- Invalid codes: bcd_in=16'hFEDA → seg=00 on all four digits; sweeping each code 0-15 on digit 0 matches the table.
- Priority: lt_n=0 with bl_n=0 → seg=7F; lt_n=1, bl_n=0 → seg=00; dig keeps rotating throughout.
- Mid-scan load and async reset: le with new data while digit 2 is active → seg changes on the next edge. rst_n pulsed low between edges → outputs off immediately, scan restarts at digit 0.
- LEADING_ZERO_BLANK_EN: bcd_in=16'h0050 → digits 3 and 2 give 00, digit 1 gives 6D, digit 0 gives 3F. bcd_in=16'h0000 → only digit 0 shows 3F. Macro undefined → 16'h0050 shows 3F,3F,6D,3F.
